// File: rtl/fifo_frame_reader.sv
// Pops framed words from a first-word-fall-through FIFO, streams the payload on a
// valid/ready output and checks the XOR trailer of each frame.
module fifo_frame_reader #(
   parameter int MAX_LEN = 64
) (
   input  logic        Read_Clk,
   input  logic        rst_n,
   input  logic        Fifo_Empty,
   input  logic [15:0] Fifo_Data,
   output logic        Fifo_Rd,
   output logic [15:0] Out_Data,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic        Out_Last,
   output logic        Frame_Done,
   output logic        Frame_Err,
   output logic [7:0]  Err_Count,
   output logic [1:0]  State_Dbg
);

   // Handshake: a word moves downstream on every rising edge where Out_Valid and
   // Out_Ready are both 1; Out_Data/Out_Last hold while Out_Valid=1 and Out_Ready=0.
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      TRAILER = 2'd2
   } state_t;

   localparam logic [11:0] MAX_L = 12'(MAX_LEN);

   state_t      state;
   logic [11:0] count;
   logic [15:0] csum;
   logic        hdr_ok;
   logic        out_free;
   logic        err_now;
   logic        done_now;

   assign hdr_ok   = (Fifo_Data[15:12] == 4'hA) && (Fifo_Data[11:0] != 12'd0) &&
                     (Fifo_Data[11:0] <= MAX_L);
   assign out_free = !Out_Valid || Out_Ready;
   // The trailer is popped regardless of Out_Ready; only payload needs room downstream.
   assign Fifo_Rd  = rst_n && !Fifo_Empty && ((state != PAYLOAD) || out_free);
   assign err_now  = Fifo_Rd && (((state == HUNT) && !hdr_ok) ||
                                 ((state == TRAILER) && (Fifo_Data != csum)));
   assign done_now = Fifo_Rd && (state == TRAILER) && (Fifo_Data == csum);
   assign State_Dbg = state;

   always_ff @(posedge Read_Clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         count      <= 12'd0;
         csum       <= 16'h0000;
         Out_Data   <= 16'h0000;
         Out_Valid  <= 1'b0;
         Out_Last   <= 1'b0;
         Frame_Done <= 1'b0;
         Frame_Err  <= 1'b0;
         Err_Count  <= 8'h00;
      end else begin
         Frame_Done <= done_now;
         Frame_Err  <= err_now;
         if (err_now && (Err_Count != 8'hFF))
            Err_Count <= Err_Count + 8'd1;

         if (Fifo_Rd && (state == PAYLOAD)) begin
            Out_Data  <= Fifo_Data;
            Out_Valid <= 1'b1;
            Out_Last  <= (count == 12'd1);
         end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
         end

         if (Fifo_Rd) begin
            case (state)
               HUNT: begin
                  if (hdr_ok) begin
                     count <= Fifo_Data[11:0];
                     csum  <= 16'h0000;
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  csum  <= csum ^ Fifo_Data;
                  count <= count - 12'd1;
                  if (count == 12'd1)
                     state <= TRAILER;
               end
               TRAILER: state <= HUNT;
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: a queue-backed FWFT FIFO model feeds frames,
// a negedge monitor pops expected payload words and pulse codes from scoreboards.
module tb_fifo_frame_reader;

   logic        Read_Clk = 1'b0;
   logic        rst_n;
   logic        Fifo_Empty;
   logic [15:0] Fifo_Data;
   logic        Fifo_Rd;
   logic [15:0] Out_Data;
   logic        Out_Valid;
   logic        Out_Ready;
   logic        Out_Last;
   logic        Frame_Done;
   logic        Frame_Err;
   logic [7:0]  Err_Count;
   logic [1:0]  State_Dbg;

   fifo_frame_reader #(.MAX_LEN(64)) dut (
      .Read_Clk  (Read_Clk),
      .rst_n     (rst_n),
      .Fifo_Empty(Fifo_Empty),
      .Fifo_Data (Fifo_Data),
      .Fifo_Rd   (Fifo_Rd),
      .Out_Data  (Out_Data),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out_Last  (Out_Last),
      .Frame_Done(Frame_Done),
      .Frame_Err (Frame_Err),
      .Err_Count (Err_Count),
      .State_Dbg (State_Dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 Read_Clk = ~Read_Clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int n_xfer = 0;
   always @(posedge Read_Clk) cyc <= cyc + 1;

   // ---------------- scoreboards ----------------
   logic [16:0] exp_q[$];      // {last, data}
   logic [1:0]  exp_ev_q[$];   // 2'b01 done, 2'b10 err
   logic [15:0] fifo_q[$];
   logic [15:0] stage_q[$];
   int          xfer_cyc_q[$];
   logic        starve = 1'b0;
   logic        hide   = 1'b0;
   logic        rd_took;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // FWFT FIFO model: pop what the DUT took on the last edge, then present the head.
   always @(posedge Read_Clk) rd_took <= Fifo_Rd;
   initial begin
      Fifo_Empty = 1'b1;
      Fifo_Data  = 16'h0000;
      forever begin
         @(posedge Read_Clk);
         #1;
         if (rd_took && fifo_q.size() > 0) void'(fifo_q.pop_front());
         #2;
         hide = starve ? ~hide : 1'b0;
         Fifo_Empty = hide || (fifo_q.size() == 0);
         Fifo_Data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
      end
   end

   // Monitor: values seen at negedge are the ones sampled at the next rising edge.
   always @(negedge Read_Clk) begin
      logic [16:0] e;
      logic [1:0]  ev;
      if (rst_n) begin
         if (Out_Valid && Out_Ready) begin
            xfer_cyc_q.push_back(cyc);
            n_xfer++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_unexpected: got %h expected none", {Out_Last, Out_Data});
            end else begin
               e = exp_q.pop_front();
               check("out_word", {15'd0, Out_Last, Out_Data}, {15'd0, e});
            end
         end
         if (Frame_Done || Frame_Err) begin
            if (exp_ev_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL pulse_unexpected: got done=%b err=%b expected none",
                        Frame_Done, Frame_Err);
            end else begin
               ev = exp_ev_q.pop_front();
               check("pulse", {30'd0, Frame_Err, Frame_Done}, {30'd0, ev});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Read_Clk);
      #2;
   endtask

   // stage_q = header, payload..., trailer; ev = expected pulse code.
   task automatic send_frame(input logic [1:0] ev);
      int n;
      n = stage_q.size();
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(stage_q[i]);
         if (i > 0 && i < n - 1) exp_q.push_back({(i == n - 2), stage_q[i]});
      end
      exp_ev_q.push_back(ev);
      stage_q.delete();
   endtask

   task automatic send_bad_hdr(input logic [15:0] w);
      fifo_q.push_back(w);
      exp_ev_q.push_back(2'b10);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || exp_ev_q.size() != 0) && k < 600) begin
         tick();
         k++;
      end
      check({name, "_drain_timeout"}, (k < 600) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fifo_q.delete(); exp_q.delete(); exp_ev_q.delete();
      #1;
      check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
      check("rst_pulses", {30'd0, Frame_Done, Frame_Err}, 32'd0);
      check("rst_out_data", {15'd0, Out_Last, Out_Data}, 32'd0);
      check("rst_err_count", {24'd0, Err_Count}, 32'd0);
      check("rst_state", {30'd0, State_Dbg}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] x;
      int base, k;
      rst_n = 1'b0;
      Out_Ready = 1'b1;

      // Reset with data already waiting: no pop, all outputs at reset values.
      stage_q = '{16'hA003, 16'h1111, 16'h2222, 16'h4444, 16'h7777};
      send_frame(2'b01);
      repeat (3) tick();
      check("rst_fifo_rd", {31'd0, Fifo_Rd}, 32'd0);
      check("rst_out_valid0", {31'd0, Out_Valid}, 32'd0);
      check("rst_err_count0", {24'd0, Err_Count}, 32'd0);
      xfer_cyc_q.delete();
      rst_n = 1'b1;
      wait_drain("good");
      check("good_xfers", xfer_cyc_q.size(), 32'd3);
      if (xfer_cyc_q.size() == 3) begin
         check("good_b2b_1", xfer_cyc_q[1] - xfer_cyc_q[0], 32'd1);
         check("good_b2b_2", xfer_cyc_q[2] - xfer_cyc_q[1], 32'd1);
      end
      check("good_err_count", {24'd0, Err_Count}, 32'd0);

      // Bad checksum then a good one-word frame.
      do_reset();
      stage_q = '{16'hA002, 16'h00FF, 16'h0F00, 16'h0000};
      send_frame(2'b10);
      stage_q = '{16'hA001, 16'h1234, 16'h1234};
      send_frame(2'b01);
      wait_drain("badsum");
      check("badsum_err_count", {24'd0, Err_Count}, 32'd1);

      // Bad headers: wrong tag, zero length, length above MAX_LEN.
      do_reset();
      send_bad_hdr(16'h5003);
      send_bad_hdr(16'hA000);
      send_bad_hdr(16'hA041);
      wait_drain("badhdr");
      check("badhdr_err_count", {24'd0, Err_Count}, 32'd3);
      check("badhdr_state", {30'd0, State_Dbg}, 32'd0);

      // Longest legal frame, length = MAX_LEN.
      stage_q.push_back(16'hA040);
      x = 16'h0000;
      for (int i = 0; i < 64; i++) begin
         stage_q.push_back(16'(i * 16'h0301 + 16'h0011));
         x = x ^ 16'(i * 16'h0301 + 16'h0011);
      end
      stage_q.push_back(x);
      send_frame(2'b01);
      wait_drain("maxlen");
      check("maxlen_err_count", {24'd0, Err_Count}, 32'd3);

      // Backpressure: hold Out_Ready low for 5 cycles once the first word is out.
      do_reset();
      Out_Ready = 1'b0;
      stage_q = '{16'hA003, 16'h1111, 16'h2222, 16'h4444, 16'h7777};
      send_frame(2'b01);
      k = 0;
      while (!Out_Valid && k < 20) begin tick(); k++; end
      check("bp_valid_seen", {31'd0, Out_Valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_fifo_rd", {31'd0, Fifo_Rd}, 32'd0);
         check("bp_data_hold", {16'd0, Out_Data}, 32'h1111);
         tick();
      end
      Out_Ready = 1'b1;
      wait_drain("bp");

      // Starvation: FIFO looks empty every other cycle.
      do_reset();
      starve = 1'b1;
      stage_q = '{16'hA003, 16'h1111, 16'h2222, 16'h4444, 16'h7777};
      send_frame(2'b01);
      wait_drain("starve");
      check("starve_err_count", {24'd0, Err_Count}, 32'd0);

      // Reset after the second payload word, then a fresh frame.
      stage_q = '{16'hA003, 16'h1111, 16'h2222, 16'h4444, 16'h7777};
      send_frame(2'b01);
      base = n_xfer;
      k = 0;
      while (n_xfer < base + 2 && k < 50) begin tick(); k++; end
      check("midrst_two_words", n_xfer - base, 32'd2);
      do_reset();
      stage_q = '{16'hA001, 16'hBEEF, 16'hBEEF};
      send_frame(2'b01);
      wait_drain("midrst");
      check("midrst_err_count", {24'd0, Err_Count}, 32'd0);
      starve = 1'b0;

      // Saturation of the error counter.
      do_reset();
      for (int i = 0; i < 260; i++) send_bad_hdr(16'h5000);
      wait_drain("sat");
      check("sat_err_count", {24'd0, Err_Count}, 32'h0000_00FF);
      send_bad_hdr(16'h0123);
      wait_drain("sat2");
      check("sat_err_hold", {24'd0, Err_Count}, 32'h0000_00FF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, maximum accepted payload length in words (1..4095).
REQ-002 SHALL have port Read_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port Fifo_Empty  input  1  upstream FIFO has no word.
REQ-005 SHALL have port Fifo_Data  input  16  upstream head word, first-word-fall-through, valid whenever Fifo_Empty=0.
REQ-006 SHALL have port Fifo_Rd  output  1  pop strobe; a word is consumed on every edge where Fifo_Rd=1.
REQ-007 SHALL have port Out_Data  output  16  registered payload word.
REQ-008 SHALL have port Out_Valid  output  1  Out_Data holds a word.
REQ-009 SHALL have port Out_Ready  input  1  downstream accepts; transfer on edge with Out_Valid=1 and Out_Ready=1.
REQ-010 SHALL have port Out_Last  output  1  Out_Data is last payload word of frame.
REQ-011 SHALL have port Frame_Done  output  1  one-cycle pulse, frame checksum good.
REQ-012 SHALL have port Frame_Err  output  1  one-cycle pulse, bad header or bad checksum.
REQ-013 SHALL have port Err_Count  output  8  saturating count of Frame_Err pulses.

Function
REQ-014 Frame format SHALL be: header word {4'hA, L[11:0]}, then L payload words, then one trailer word equal to XOR of all L payload words.
REQ-015 FSM SHALL have states HUNT, PAYLOAD, TRAILER; reset state HUNT.
REQ-016 Fifo_Rd SHALL equal !Fifo_Empty && (HUNT || TRAILER || (PAYLOAD && (!Out_Valid || Out_Ready))); combinational, never asserted while Fifo_Empty=1.
REQ-017 HUNT, word popped: header valid if [15:12]=4'hA and 1<=L<=MAX_LEN -> load remaining count=L, clear checksum, go PAYLOAD.
REQ-018 HUNT, invalid header popped: word discarded, Frame_Err pulse next cycle, stay HUNT.
REQ-019 PAYLOAD, word popped: Out_Data<=word, Out_Valid<=1 same edge (latency 1 cycle pop-to-valid), checksum ^= word, count decrements; Out_Last<=1 when count was 1, then go TRAILER.
REQ-020 Out_Valid SHALL clear on a transfer edge unless a new word is loaded on that same edge; Out_Data/Out_Last SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-021 Back-to-back throughput SHALL be one payload word per cycle when Out_Ready=1 and FIFO non-empty.
REQ-022 TRAILER, word popped: equal to checksum -> Frame_Done pulse; else Frame_Err pulse; both go HUNT. TRAILER pop SHALL NOT depend on Out_Ready; last payload word may still be pending on Out_*.
REQ-023 Frame_Done and Frame_Err SHALL never be high in the same cycle and SHALL each last exactly one cycle.
REQ-024 Err_Count SHALL increment on each Frame_Err pulse and saturate at 8'hFF.
REQ-025 Fifo_Empty=1 in any state SHALL stall the FSM with no state, count or checksum change.
REQ-026 Remaining count SHALL be 12 bits; no wrap beyond 0 (transition at count=1).

Reset
REQ-027 rst_n=0 SHALL immediately force state HUNT, Out_Valid=0, Out_Last=0, Out_Data=16'h0000, Frame_Done=0, Frame_Err=0, Err_Count=0, count=0, checksum=0.
REQ-028 Reset mid-frame SHALL abandon the frame; no pulse generated; after release the next popped word is treated as a header.
REQ-029 Fifo_Rd SHALL be 0 while rst_n=0.

Verification
REQ-030 Good frame: FIFO holds A003,1111,2222,4444,7777, Out_Ready=1 -> Out_Data 1111,2222,4444 on consecutive cycles, Out_Last with 4444, Frame_Done one pulse, Err_Count=0.
REQ-031 Bad checksum: A002,00FF,0F00,0000 -> two payload words output, Frame_Err pulse, Err_Count=1, next word A001 accepted as header.
REQ-032 Bad header: 5003 then A000 then A041 (MAX_LEN=64) -> three Frame_Err pulses, nothing on Out_*, Err_Count=3, state HUNT.
REQ-033 Backpressure: good 3-word frame, Out_Ready=0 for 5 cycles after first Out_Valid -> Fifo_Rd=0 during stall, Out_Data held 1111, no word lost or duplicated.
REQ-034 Starvation and reset: Fifo_Empty=1 between every word -> identical output sequence to REQ-030; rst_n pulsed after second payload word -> all outputs reset values, no pulse, following A001,BEEF,BEEF gives Frame_Done.
REQ-035 Saturation: 260 bad headers -> Err_Count=8'hFF held.
